// File: rtl/palette_fade_engine.sv
// palette_fade_engine
//   Banked RGB444 palette RAM with a registered lookup, transparent-key detect
//   and a frame-driven fade to/from black for scene transitions.
//   Optional feature macro: PALETTE_FLASH_EN (adds flash_req_i / flash_active_o).
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   frame_tick_i        one-cycle pulse per frame
//   wr_en_i/_bank_i/_idx_i/_rgb_i   palette write port
//   rd_en_i/_bank_i/_idx_i          lookup request (1-cycle latency)
//   fade_out_req_i, fade_in_req_i   fade start requests
//   red_o, green_o, blue_o          scaled colour
//   rd_valid_o, transparent_o       lookup valid, raw colour equals KEY_RGB
//   fade_busy_o, fade_level_o       fade in progress, brightness (0 black .. 15 full)
module palette_fade_engine #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned BANK_W    = 3,
  parameter logic [11:0] KEY_RGB   = 12'hE1E,
  parameter int unsigned FADE_DIV  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_tick_i,
  input  logic              wr_en_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [11:0]       wr_rgb_i,
  input  logic              rd_en_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic              fade_out_req_i,
  input  logic              fade_in_req_i,
  output logic [3:0]        red_o,
  output logic [3:0]        green_o,
  output logic [3:0]        blue_o,
  output logic              rd_valid_o,
  output logic              transparent_o,
  output logic              fade_busy_o,
  output logic [3:0]        fade_level_o
`ifdef PALETTE_FLASH_EN
  ,
  input  logic              flash_req_i,
  output logic              flash_active_o
`endif
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned DivW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  typedef enum logic [1:0] {StFull, StFadeOut, StBlack, StFadeIn} fade_st_e;

  logic [11:0]     mem_q [NUM_BANKS][Entries];
  logic            wr_in_range, rd_in_range;
  logic [11:0]     raw_rgb, out_rgb;
  logic            raw_is_key;
  logic [3:0]      red_q, green_q, blue_q, fade_level_q;
  logic            rd_valid_q, transparent_q, fade_busy_q;
  fade_st_e        state_q;
  logic [DivW-1:0] div_cnt_q;

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = 8'(c) * (8'(lvl) + 8'd1);
    return prod[7:4];
  endfunction

  assign wr_in_range = 32'(wr_bank_i) < NUM_BANKS;
  assign rd_in_range = 32'(rd_bank_i) < NUM_BANKS;

  // Palette RAM is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_in_range) begin
      mem_q[wr_bank_i][wr_idx_i] <= wr_rgb_i;
    end
  end

  // Write-first bypass on a same-entry collision.
  always_comb begin
    raw_rgb = 12'h000;
    if (rd_in_range) begin
      if (wr_en_i && wr_bank_i == rd_bank_i && wr_idx_i == rd_idx_i) begin
        raw_rgb = wr_rgb_i;
      end else begin
        raw_rgb = mem_q[rd_bank_i][rd_idx_i];
      end
    end
  end

  assign raw_is_key = rd_in_range && (raw_rgb == KEY_RGB);

`ifdef PALETTE_FLASH_EN
  logic [3:0] flash_cnt_q;

  // Counts remaining flash frames; odd counts force white on opaque pixels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flash_cnt_q <= 4'd0;
    end else if (flash_req_i && flash_cnt_q == 4'd0) begin
      flash_cnt_q <= 4'd8;
    end else if (frame_tick_i && flash_cnt_q != 4'd0) begin
      flash_cnt_q <= flash_cnt_q - 4'd1;
    end
  end

  assign flash_active_o = flash_cnt_q != 4'd0;

  always_comb begin
    out_rgb = {scale(raw_rgb[11:8], fade_level_q), scale(raw_rgb[7:4], fade_level_q),
               scale(raw_rgb[3:0], fade_level_q)};
    if (flash_active_o && flash_cnt_q[0] && !raw_is_key) begin
      out_rgb = 12'hFFF;
    end
  end
`else
  assign out_rgb = {scale(raw_rgb[11:8], fade_level_q), scale(raw_rgb[7:4], fade_level_q),
                    scale(raw_rgb[3:0], fade_level_q)};
`endif

  // Lookup output registers; hold while rd_en_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_q         <= 4'h0;
      green_q       <= 4'h0;
      blue_q        <= 4'h0;
      rd_valid_q    <= 1'b0;
      transparent_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        red_q         <= out_rgb[11:8];
        green_q       <= out_rgb[7:4];
        blue_q        <= out_rgb[3:0];
        transparent_q <= raw_is_key;
      end
    end
  end

  // Fade FSM; fade_out wins in FULL, fade_in wins in BLACK, requests ignored while busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StFull;
      fade_level_q <= 4'd15;
      fade_busy_q  <= 1'b0;
      div_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StFull: begin
          if (fade_out_req_i) begin
            state_q     <= StFadeOut;
            fade_busy_q <= 1'b1;
            div_cnt_q   <= '0;
          end
        end
        StFadeOut: begin
          if (frame_tick_i) begin
            if (div_cnt_q == DivW'(FADE_DIV - 1)) begin
              div_cnt_q <= '0;
              if (fade_level_q != 4'd0) fade_level_q <= fade_level_q - 4'd1;
              if (fade_level_q <= 4'd1) begin
                state_q     <= StBlack;
                fade_busy_q <= 1'b0;
              end
            end else begin
              div_cnt_q <= div_cnt_q + DivW'(1);
            end
          end
        end
        StBlack: begin
          if (fade_in_req_i) begin
            state_q     <= StFadeIn;
            fade_busy_q <= 1'b1;
            div_cnt_q   <= '0;
          end
        end
        StFadeIn: begin
          if (frame_tick_i) begin
            if (div_cnt_q == DivW'(FADE_DIV - 1)) begin
              div_cnt_q <= '0;
              if (fade_level_q != 4'd15) fade_level_q <= fade_level_q + 4'd1;
              if (fade_level_q >= 4'd14) begin
                state_q     <= StFull;
                fade_busy_q <= 1'b0;
              end
            end else begin
              div_cnt_q <= div_cnt_q + DivW'(1);
            end
          end
        end
        default: state_q <= StFull;
      endcase
    end
  end

  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign rd_valid_o    = rd_valid_q;
  assign transparent_o = transparent_q;
  assign fade_busy_o   = fade_busy_q;
  assign fade_level_o  = fade_level_q;

endmodule

// File: tb/tb_palette_fade_engine.sv
// Self-checking bench for palette_fade_engine: scoreboard of expected lookups,
// direct checks of reset values and fade progression.
module tb_palette_fade_engine;

  localparam int unsigned NB = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_bank = '0;
  logic [3:0] wr_idx = '0;
  logic [11:0] wr_rgb = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_bank = '0;
  logic [3:0] rd_idx = '0;
  logic       fade_out_req = 1'b0;
  logic       fade_in_req = 1'b0;
  logic [3:0] red, green, blue, fade_level;
  logic       rd_valid, transparent, fade_busy;

  typedef struct packed {
    logic [11:0] rgb;
    logic        trans;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] model_mem [NB][16];
  int unsigned exp_level = 15;
  int          n_checks = 0;
  int          n_fails = 0;

  palette_fade_engine #(
    .IDX_W(4), .NUM_BANKS(NB), .BANK_W(3), .KEY_RGB(12'hE1E), .FADE_DIV(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick),
    .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_idx_i(wr_idx), .wr_rgb_i(wr_rgb),
    .rd_en_i(rd_en), .rd_bank_i(rd_bank), .rd_idx_i(rd_idx),
    .fade_out_req_i(fade_out_req), .fade_in_req_i(fade_in_req),
    .red_o(red), .green_o(green), .blue_o(blue), .rd_valid_o(rd_valid),
    .transparent_o(transparent), .fade_busy_o(fade_busy), .fade_level_o(fade_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_of(input logic [11:0] raw, input logic in_range,
                                     input int unsigned lvl);
    exp_t e;
    logic [11:0] c;
    c = in_range ? raw : 12'h000;
    e.rgb[11:8] = 4'((int'(c[11:8]) * (lvl + 1)) / 16);
    e.rgb[7:4]  = 4'((int'(c[7:4]) * (lvl + 1)) / 16);
    e.rgb[3:0]  = 4'((int'(c[3:0]) * (lvl + 1)) / 16);
    e.trans     = in_range && (c == 12'hE1E);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int b, input int i, input logic [11:0] v);
    wr_en = 1'b1; wr_bank = 3'(b); wr_idx = 4'(i); wr_rgb = v;
    if (b < int'(NB)) model_mem[b][i] = v;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 5 && sb_q.size() != 0; k++) cycle();
    if (sb_q.size() != 0) begin
      check("sb_timeout", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
  endtask

  task automatic do_read(input int b, input int i);
    rd_en = 1'b1; rd_bank = 3'(b); rd_idx = 4'(i);
    sb_q.push_back(expect_of((b < int'(NB)) ? model_mem[b][i] : 12'h000, b < int'(NB),
                             exp_level));
    cycle();
    rd_en = 1'b0;
    drain();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic pulse_req(input logic o, input logic i);
    fade_out_req = o; fade_in_req = i;
    cycle();
    fade_out_req = 1'b0; fade_in_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
        check("transparent", {31'd0, transparent}, {31'd0, e.trans});
      end
    end
  end

  initial begin
    logic [11:0] held;
    repeat (2) cycle();
    check("rst_rgb", {20'd0, red, green, blue}, 0);
    check("rst_valid", {31'd0, rd_valid}, 0);
    check("rst_transp", {31'd0, transparent}, 0);
    check("rst_busy", {31'd0, fade_busy}, 0);
    check("rst_level", {28'd0, fade_level}, 15);
    rst = 1'b0;
    cycle();

    // Basic lookups and key detection at full brightness.
    do_write(2, 5, 12'hA73);
    do_read(2, 5);
    do_write(0, 0, 12'hE1E);
    do_read(0, 0);
    held = {red, green, blue};
    cycle();
    check("hold_rgb", {20'd0, red, green, blue}, {20'd0, held});
    check("hold_valid", {31'd0, rd_valid}, 0);

    // Write-first collision.
    do_write(1, 3, 12'h000);
    wr_en = 1'b1; wr_bank = 3'd1; wr_idx = 4'd3; wr_rgb = 12'h5B8;
    rd_en = 1'b1; rd_bank = 3'd1; rd_idx = 4'd3;
    model_mem[1][3] = 12'h5B8;
    sb_q.push_back(expect_of(12'h5B8, 1'b1, exp_level));
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    drain();

    // Fade out over 30 ticks with an ignored fade-in request midway.
    do_write(3, 1, 12'hFFF);
    pulse_req(1'b0, 1'b1);
    check("full_ignores_in", {31'd0, fade_busy}, 0);
    pulse_req(1'b1, 1'b1);
    check("fade_out_busy", {31'd0, fade_busy}, 1);
    for (int t = 1; t <= 30; t++) begin
      tick();
      exp_level = 15 - t / 2;
      check("out_level", {28'd0, fade_level}, 32'(exp_level));
      check("out_busy", {31'd0, fade_busy}, (t < 30) ? 1 : 0);
      if (t == 10) begin
        pulse_req(1'b0, 1'b1);
        check("busy_ignores_in", {28'd0, fade_level}, 32'(exp_level));
      end
    end
    do_read(3, 1);
    do_read(0, 0);
    pulse_req(1'b1, 1'b0);
    check("black_ignores_out", {31'd0, fade_busy}, 0);

    // Fade back in for 14 ticks, then reset mid-fade.
    pulse_req(1'b1, 1'b1);
    check("fade_in_busy", {31'd0, fade_busy}, 1);
    for (int t = 1; t <= 14; t++) tick();
    exp_level = 7;
    check("in_level", {28'd0, fade_level}, 7);
    do_write(4, 9, 12'hF84);
    do_read(4, 9);
    #2 rst = 1'b1;
    #2;
    check("mid_rst_level", {28'd0, fade_level}, 15);
    check("mid_rst_busy", {31'd0, fade_busy}, 0);
    check("mid_rst_rgb", {20'd0, red, green, blue}, 0);
    cycle();
    rst = 1'b0;
    exp_level = 15;
    cycle();

    // Out-of-range bank reads and writes.
    do_read(NB, 5);
    do_write(NB, 5, 12'h123);
    do_write(NB + 1, 3, 12'h456);
    do_read(2, 5);
    do_read(1, 3);
    do_read(NB, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
